// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high/low phase lengths of a clk-synchronous divided clock and reports lock/error status
//
// Optional build macro: CLK_MON_DUTY_EN
//   defined   - a period matches only if high == EXP_HIGH and low == EXP_LOW (duty cycle checked)
//   undefined - a period matches if high + low == EXP_HIGH + EXP_LOW (period only)
//
// Ports:
//   clk        system clock; div_in is synchronous to it
//   rst_n      asynchronous active-low reset
//   div_in     divided clock under test
//   clr_err    synchronous clear of err_sticky (an error in the same cycle wins)
//   high_len   last measured high-phase length in clk cycles
//   low_len    last measured low-phase length in clk cycles
//   meas_valid one-cycle pulse when a full period has been measured
//   locked     LOCK_PERIODS consecutive matching periods seen
//   err        one-cycle pulse on a mismatch or timeout
//   err_sticky latched error flag
module clk_div_monitor #(
    parameter int CNT_W        = 8,
    parameter int EXP_HIGH     = 4,
    parameter int EXP_LOW      = 4,
    parameter int LOCK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             err_sticky
);
    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0] LOCK_N = 4'(LOCK_PERIODS);
    state_t           state;
    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       match_cnt;
    logic             rise, fall, timeout, eval, match, bad;
    assign rise = div_in & ~prev;
    assign fall = ~div_in & prev;
    // A saturated counter while measuring means the divider has stopped toggling.
    assign timeout = (state != IDLE) && (cnt == CNT_MAX);
    assign eval = (state == MEAS_LOW) && rise && !timeout;
`ifdef CLK_MON_DUTY_EN
    assign match = (high_len == CNT_W'(EXP_HIGH)) && (cnt == CNT_W'(EXP_LOW));
`else
    // One extra bit so the sum of two saturated lengths cannot wrap.
    logic [CNT_W:0] sum;
    assign sum = {1'b0, high_len} + {1'b0, cnt};
    assign match = sum == (CNT_W+1)'(EXP_HIGH + EXP_LOW);
`endif
    assign bad = timeout || (eval && !match);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            match_cnt  <= '0;
            high_len   <= '0;
            low_len    <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prev       <= div_in;
            cnt        <= (rise || fall) ? CNT_W'(1) : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            meas_valid <= eval;
            err        <= bad;
            err_sticky <= bad | (err_sticky & ~clr_err);
            // Lock follows the match count one cycle later, so it lags meas_valid/err.
            locked     <= match_cnt == LOCK_N;
            if (bad)
                match_cnt <= '0;
            else if (eval && match_cnt != LOCK_N)
                match_cnt <= match_cnt + 1'b1;
            if (timeout)
                state <= IDLE;
            else
                case (state)
                    IDLE: if (rise) state <= MEAS_HIGH;
                    MEAS_HIGH: if (fall) begin
                        high_len <= cnt;
                        state    <= MEAS_LOW;
                    end
                    MEAS_LOW: if (rise) begin
                        low_len <= cnt;
                        state   <= MEAS_HIGH;
                    end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: scoreboard bench for clk_div_monitor with default parameters
module tb_clk_div_monitor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_in = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] high_len, low_len;
    logic       meas_valid, locked, err, err_sticky;
    int         tests = 0;
    int         fails = 0;
    int         err_cnt = 0;
    int         e0;
    typedef struct {int h; int l; bit e;} exp_t;
    exp_t q[$];
    exp_t cur;
`ifdef CLK_MON_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    always #5 clk = ~clk;

    clk_div_monitor dut (
        .clk(clk), .rst_n(rst_n), .div_in(div_in), .clr_err(clr_err),
        .high_len(high_len), .low_len(low_len), .meas_valid(meas_valid),
        .locked(locked), .err(err), .err_sticky(err_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit bad(input int h, input int l);
        return DUTY ? (h != 4 || l != 4) : (h + l != 8);
    endfunction

    task automatic push(input int h, input int l);
        q.push_back('{h, l, bad(h, l)});
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            div_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic period(input int h, input int l);
        push(h, l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high_len"}, high_len, 0);
        chk({tag, "_low_len"}, low_len, 0);
        chk({tag, "_meas_valid"}, meas_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_sticky"}, err_sticky, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_cnt++;
            if (meas_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL meas_unexpected: got meas_valid=1 expected no pending period");
                end else begin
                    cur = q.pop_front();
                    chk("sb_high_len", high_len, cur.h);
                    chk("sb_low_len", low_len, cur.l);
                    chk("sb_err", err, cur.e);
                end
            end
        end
    end

    initial begin
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Clean 4/4 from reset
        repeat (3) period(4, 4);
        chk("a_locked", locked, 1);
        chk("a_sticky", err_sticky, 0);
        chk("a_err_cnt", err_cnt, 0);
        // 5/3: period-only passes, duty check fails
        repeat (3) period(5, 3);
        chk("b_locked", locked, !DUTY);
        chk("b_sticky", err_sticky, DUTY);
        repeat (3) period(4, 4);
        chk("b_relock", locked, 1);
        // Inject one 4/5 period after lock
        push(4, 5);
        drive(1'b1, 4);
        drive(1'b0, 5);
        push(4, 4);
        drive(1'b1, 1);
        chk("c_err_pulse", err, 1);
        chk("c_locked_still", locked, 1);
        chk("c_sticky", err_sticky, 1);
        drive(1'b1, 1);
        chk("c_locked_drop", locked, 0);
        drive(1'b1, 2);
        drive(1'b0, 4);
        push(4, 4);
        drive(1'b1, 4);
        chk("c_locked_one", locked, 0);
        drive(1'b0, 4);
        push(4, 4);
        drive(1'b1, 2);
        chk("c_relock", locked, 1);
        drive(1'b1, 2);
        drive(1'b0, 4);
        // clr_err together with a mismatch: set wins
        push(4, 5);
        drive(1'b1, 4);
        drive(1'b0, 5);
        push(4, 4);
        clr_err = 1'b1;
        drive(1'b1, 1);
        clr_err = 1'b0;
        chk("d_err_pulse", err, 1);
        chk("d_set_wins", err_sticky, 1);
        drive(1'b1, 3);
        drive(1'b0, 4);
        // clr_err alone
        push(4, 4);
        clr_err = 1'b1;
        drive(1'b1, 1);
        clr_err = 1'b0;
        chk("d_cleared", err_sticky, 0);
        drive(1'b1, 3);
        drive(1'b0, 4);
        repeat (2) period(4, 4);
        chk("e_locked_before", locked, 1);
        // Stuck-high divider
        e0 = err_cnt;
        drive(1'b1, 300);
        chk("e_timeout_once", err_cnt - e0, 1);
        chk("e_locked", locked, 0);
        chk("e_sticky", err_sticky, 1);
        drive(1'b0, 4);
        repeat (3) period(4, 4);
        chk("e_no_more_err", err_cnt - e0, 1);
        chk("e_relock", locked, 1);
        // Asynchronous reset in the middle of a low phase
        push(4, 4);
        drive(1'b1, 4);
        drive(1'b0, 2);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        q.delete();
        drive(1'b0, 3);
        rst_n = 1'b1;
        e0 = err_cnt;
        drive(1'b0, 2);
        repeat (3) period(4, 4);
        drive(1'b1, 2);
        chk("f_locked", locked, 1);
        chk("f_sticky", err_sticky, 0);
        chk("f_no_err", err_cnt - e0, 0);
        chk("f_queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
